// File: rtl/rssb_pkg.sv
// Shared state encoding and default sizing for the RSSB sequencer.
package rssb_pkg;

    localparam int DEF_WIDTH  = 8;
    localparam int DEF_ADDR_W = 8;
    localparam logic [DEF_ADDR_W-1:0] DEF_HALT_ADDR = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_EXEC,
        S_STORE,
        S_HALT
    } rssb_state_t;

endpackage

// File: rtl/register.sv
// Loadable register with asynchronous active-high clear.
module register #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             write,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;

    always_comb begin
        out_d = out_q;
        if (write) out_d = in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) out_q <= '0;
        else     out_q <= out_d;
    end

    assign out = out_q;

endmodule

// File: rtl/rssb_alu.sv
// Reverse-subtract datapath: R = D - ACC (wrapping), borrow is the sign of R.
module rssb_alu
    import rssb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic signed [WIDTH-1:0] d,
    input  logic signed [WIDTH-1:0] acc,
    output logic signed [WIDTH-1:0] r,
    output logic                    borrow
);

    always_comb begin
        r      = d - acc;
        borrow = r[WIDTH-1];
    end

endmodule

// File: rtl/rssb_sequencer.sv
// RSSB instruction sequencer: FETCH/LOAD/EXEC/STORE over a req/ack memory port,
// driving the PC and ACC register instances.
module rssb_sequencer
    import rssb_pkg::*;
#(
    parameter int                WIDTH     = DEF_WIDTH,
    parameter int                ADDR_W    = DEF_ADDR_W,
    parameter logic [ADDR_W-1:0] HALT_ADDR = {ADDR_W{1'b1}}
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    run,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [WIDTH-1:0]        mem_wdata,
    input  logic [WIDTH-1:0]        mem_rdata,
    input  logic                    mem_ack,
    output logic [ADDR_W-1:0]       pc,
    output logic signed [WIDTH-1:0] acc,
    output logic                    borrow,
    output logic                    halted
);

    rssb_state_t state_q, state_d;
    logic        borrow_q, borrow_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic signed [WIDTH-1:0] d_q, d_d;

    logic                    rst_hi;
    logic                    pc_we;
    logic                    acc_we;
    logic [ADDR_W-1:0]       pc_next;
    logic signed [WIDTH-1:0] alu_r;
    logic                    alu_borrow;
    logic [WIDTH-1:0]        acc_out;

    // The register primitive clears on a high reset; this block's reset is active-low.
    assign rst_hi = ~rst;

    register #(.WIDTH(ADDR_W)) u_pc (
        .clk   (clk),
        .rst   (rst_hi),
        .write (pc_we),
        .in    (pc_next),
        .out   (pc)
    );

    register #(.WIDTH(WIDTH)) u_acc (
        .clk   (clk),
        .rst   (rst_hi),
        .write (acc_we),
        .in    (alu_r),
        .out   (acc_out)
    );

    assign acc = acc_out;

    rssb_alu #(.WIDTH(WIDTH)) u_alu (
        .d      (d_q),
        .acc    (acc),
        .r      (alu_r),
        .borrow (alu_borrow)
    );

    assign pc_next = pc + (borrow_q ? ADDR_W'(2) : ADDR_W'(1));
    assign borrow  = borrow_q;
    assign halted  = (state_q == S_HALT);

    always_comb begin
        state_d   = state_q;
        borrow_d  = borrow_q;
        a_d       = a_q;
        d_d       = d_q;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        pc_we     = 1'b0;
        acc_we    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc;
                if (mem_ack) begin
                    a_d     = mem_rdata[ADDR_W-1:0];
                    state_d = (mem_rdata[ADDR_W-1:0] == HALT_ADDR) ? S_HALT : S_LOAD;
                end
            end
            S_LOAD: begin
                mem_req  = 1'b1;
                mem_addr = a_q;
                if (mem_ack) begin
                    d_d     = mem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                acc_we   = 1'b1;
                borrow_d = alu_borrow;
                state_d  = S_STORE;
            end
            S_STORE: begin
                // ACC already holds R here, so it doubles as the write data.
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = a_q;
                mem_wdata = acc;
                if (mem_ack) begin
                    pc_we   = 1'b1;
                    state_d = run ? S_FETCH : S_IDLE;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            borrow_q <= borrow_d;
        end
    end

    // Operand address and loaded word are only consumed after being captured.
    always_ff @(posedge clk) begin
        a_q <= a_d;
        d_q <= d_d;
    end

endmodule

// File: tb/tb_rssb_sequencer.sv
// Self-checking bench for rssb_sequencer: vector table, directed corner sequences,
// and random programs checked against an instruction-level reference model.
module tb_rssb_sequencer;

    logic              clk;
    logic              rst;
    logic              run;
    logic              mem_req;
    logic              mem_we;
    logic [7:0]        mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;
    logic              mem_ack;
    logic [7:0]        pc;
    logic signed [7:0] acc;
    logic              borrow;
    logic              halted;
    logic [7:0]        acc_u;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];

    int  wcnt, cur_wait, xfer_n;
    int  wait_tab [3];
    bit  rand_wait, chk_stores;
    int  n_checks, n_err;
    int  st_idx;
    logic [7:0] exp_sa [$];
    logic [7:0] exp_sd [$];
    logic [7:0] exp_pc, exp_acc;
    bit  exp_b, model_ok;

    bit         hold;
    logic       h_we;
    logic [7:0] h_addr, h_wd;

    typedef struct {
        logic [7:0] d;
        logic [7:0] a0;
        logic [7:0] r;
        logic       b;
    } vec_t;
    vec_t vt [8];

    rssb_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .pc        (pc),
        .acc       (acc),
        .borrow    (borrow),
        .halted    (halted)
    );

    assign acc_u     = acc;
    assign mem_ack   = mem_req && (wcnt >= cur_wait);
    assign mem_rdata = mem[mem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at a falling edge; advances one clock and services the memory.
    task automatic tick();
        logic s_req, s_ack, s_we;
        logic [7:0] s_addr, s_wd;
        s_req  = mem_req;
        s_ack  = mem_ack;
        s_we   = mem_we;
        s_addr = mem_addr;
        s_wd   = mem_wdata;
        @(posedge clk);
        #1;
        if (s_req && s_ack) begin
            if (s_we) begin
                mem[s_addr] = s_wd;
                if (chk_stores) begin
                    if (st_idx < exp_sa.size())
                        check("store", {s_addr, s_wd}, {exp_sa[st_idx], exp_sd[st_idx]});
                    else
                        check("store_count", st_idx + 1, exp_sa.size());
                end
                st_idx++;
            end
            xfer_n++;
            wcnt = 0;
            cur_wait = rand_wait ? int'($urandom_range(0, 3)) : wait_tab[xfer_n % 3];
        end else if (s_req) begin
            wcnt++;
        end
        hold   = s_req && !s_ack;
        h_we   = s_we;
        h_addr = s_addr;
        h_wd   = s_wd;
        @(negedge clk);
        if (hold)
            check("hold_stable", {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, h_we, h_addr, h_wd});
    endtask

    task automatic assert_reset();
        rst = 1'b0;
        #1;
        wcnt   = 0;
        xfer_n = 0;
        hold   = 1'b0;
        st_idx = 0;
        cur_wait = rand_wait ? int'($urandom_range(0, 3)) : wait_tab[0];
    endtask

    task automatic release_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic wait_halt(input int budget);
        for (int i = 0; i < budget && !halted; i++) tick();
        check("halt_reached", halted, 1);
    endtask

    task automatic fill_mem(input logic [7:0] v);
        for (int k = 0; k < 256; k++) mem[k] = v;
    endtask

    // Instruction-level reference: runs the program image in mem from reset state.
    task automatic model_run();
        logic [7:0] p, a, r, ac;
        bit b;
        ref_mem = mem;
        p = 8'd0; ac = 8'd0; b = 1'b0;
        exp_sa.delete();
        exp_sd.delete();
        model_ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            a = ref_mem[p];
            if (a == 8'hFF) begin
                model_ok = 1'b1;
                break;
            end
            r  = ref_mem[a] - ac;
            b  = ($signed(r) < 0);
            ac = r;
            ref_mem[a] = r;
            exp_sa.push_back(a);
            exp_sd.push_back(r);
            p = p + (b ? 8'd2 : 8'd1);
        end
        exp_pc  = p;
        exp_acc = ac;
        exp_b   = b;
    endtask

    initial begin
        int reqs, cyc, held, diffs, tries;
        bit done;
        logic [7:0] p1, p2;

        n_checks = 0; n_err = 0;
        rst = 1'b1; run = 1'b0;
        rand_wait = 1'b0; chk_stores = 1'b0;
        wait_tab = '{0, 0, 0};
        wcnt = 0; cur_wait = 0; xfer_n = 0; st_idx = 0; hold = 1'b0;

        vt[0] = '{d: 8'd10,  a0: 8'd0,   r: 8'd10,  b: 1'b0};
        vt[1] = '{d: 8'd1,   a0: 8'd3,   r: 8'hFE,  b: 1'b1};
        vt[2] = '{d: 8'h80,  a0: 8'd1,   r: 8'h7F,  b: 1'b0};
        vt[3] = '{d: 8'd0,   a0: 8'd1,   r: 8'hFF,  b: 1'b1};
        vt[4] = '{d: 8'h7F,  a0: 8'h80,  r: 8'hFF,  b: 1'b1};
        vt[5] = '{d: 8'd5,   a0: 8'd5,   r: 8'd0,   b: 1'b0};
        vt[6] = '{d: 8'hFF,  a0: 8'hFF,  r: 8'd0,   b: 1'b0};
        vt[7] = '{d: 8'h80,  a0: 8'h7F,  r: 8'h01,  b: 1'b0};

        // Reset state
        fill_mem(8'hFF);
        assert_reset();
        check("rst_outputs", {mem_req, mem_we, mem_addr, mem_wdata, pc, acc_u, borrow, halted}, 0);
        release_reset();
        check("idle_no_req", mem_req, 0);

        // Table: first instruction sets ACC to a0, second computes d - a0
        for (int i = 0; i < 8; i++) begin
            run = 1'b0;
            assert_reset();
            fill_mem(8'hFF);
            mem[0]     = 8'h80;
            mem[8'h80] = vt[i].a0;
            p1 = vt[i].a0[7] ? 8'd2 : 8'd1;
            mem[p1]    = 8'h81;
            mem[8'h81] = vt[i].d;
            p2 = p1 + (vt[i].b ? 8'd2 : 8'd1);
            release_reset();
            run = 1'b1;
            wait_halt(100);
            check($sformatf("vec%0d_acc", i), acc_u, vt[i].r);
            check($sformatf("vec%0d_borrow", i), borrow, vt[i].b);
            check($sformatf("vec%0d_mem", i), mem[8'h81], vt[i].r);
            check($sformatf("vec%0d_pc", i), pc, p2);
        end

        // Zero-wait instruction, run dropped during EXEC, then a halt fetch
        run = 1'b0;
        assert_reset();
        fill_mem(8'hFF);
        mem[0] = 8'd5;
        mem[5] = 8'd10;
        release_reset();
        run = 1'b1;
        reqs = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (mem_req) reqs++;
            if (i == 0) check("first_fetch", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 8'd0});
            if (i == 2) run = 1'b0;
            if (i == 3) check("store_phase", {mem_we, mem_wdata, acc_u}, {1'b1, 8'd10, 8'd10});
        end
        check("xfer_count", reqs, 3);
        tick();
        check("after_store", {mem_req, pc, acc_u, borrow, mem[5]}, {1'b0, 8'd1, 8'd10, 1'b0, 8'd10});
        tick();
        tick();
        check("idle_stays", {mem_req, halted}, 0);
        run = 1'b1;
        tick();
        check("halt_fetch", {mem_req, mem_addr}, {1'b1, 8'd1});
        tick();
        check("halted_now", {halted, mem_req}, {1'b1, 1'b0});
        reqs = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (mem_req) reqs++;
        end
        check("halt_no_req", reqs, 0);
        check("halt_pc", pc, 1);

        // Three wait cycles on LOAD, then reset while the second LOAD is pending
        run = 1'b0;
        wait_tab = '{0, 3, 0};
        assert_reset();
        fill_mem(8'hFF);
        mem[0]     = 8'h10;
        mem[8'h10] = 8'd7;
        mem[1]     = 8'h11;
        mem[8'h11] = 8'd2;
        release_reset();
        run = 1'b1;
        tick();
        cyc = 0; held = 0; done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            cyc++;
            if (mem_req && !mem_we && mem_addr == 8'h10) held++;
            if (mem_req && mem_we && mem_ack) done = 1'b1;
            else tick();
        end
        check("instr_cycles", cyc, 7);
        check("load_held", held, 4);
        tick();
        check("second_fetch", {pc, acc_u, mem_addr, mem[8'h10]}, {8'd1, 8'd7, 8'd1, 8'd7});
        for (int i = 0; i < 5 && !(mem_req && !mem_we && mem_addr == 8'h11); i++) tick();
        check("load2_pending", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 8'h11});
        assert_reset();
        check("midload_rst_bus", {mem_req, mem_we, mem_addr, mem_wdata}, 0);
        check("midload_rst_regs", {pc, acc_u, borrow, halted}, 0);
        run = 1'b0;
        release_reset();
        tick();
        tick();
        check("post_rst_idle", mem_req, 0);
        run = 1'b1;
        tick();
        check("post_rst_fetch", {mem_req, mem_addr}, {1'b1, 8'd0});
        wait_tab = '{0, 0, 0};

        // PC wrap: walk PC up to 255, where a borrowing instruction wraps it to 1
        run = 1'b0;
        assert_reset();
        fill_mem(8'h00);
        release_reset();
        run = 1'b1;
        for (int i = 0; i < 3000 && pc != 8'd200; i++) tick();
        check("reach_pc200", pc, 200);
        mem[1]     = 8'hFF;
        mem[8'h40] = 8'd3;
        mem[8'h41] = 8'd6;
        mem[8'h42] = 8'd1;
        mem[253]   = 8'h40;
        mem[254]   = 8'h41;
        mem[255]   = 8'h42;
        wait_halt(2000);
        check("wrap_result", {acc_u, borrow, pc, mem[8'h42]}, {8'hFE, 1'b1, 8'd1, 8'hFE});

        // Random programs with random wait states against the reference model
        rand_wait = 1'b1;
        for (int t = 0; t < 25; t++) begin
            tries = 0;
            do begin
                for (int k = 0; k < 256; k++)
                    mem[k] = ($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom);
                model_run();
                tries++;
            end while (!model_ok && tries < 50);
            if (model_ok) begin
                run = 1'b0;
                chk_stores = 1'b0;
                assert_reset();
                release_reset();
                chk_stores = 1'b1;
                run = 1'b1;
                wait_halt(1200);
                chk_stores = 1'b0;
                check($sformatf("rnd%0d_stores", t), st_idx, exp_sa.size());
                check($sformatf("rnd%0d_state", t), {pc, acc_u, borrow}, {exp_pc, exp_acc, exp_b});
                diffs = 0;
                for (int k = 0; k < 256; k++) if (mem[k] !== ref_mem[k]) diffs++;
                check($sformatf("rnd%0d_mem", t), diffs, 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/rssb_sequencer.md
# rssb_sequencer

Multi-cycle instruction sequencer for the RSSB (reverse-subtract, skip-if-borrow) processor. Fetches the single operand address at PC, reads the memory word, computes mem[A] − ACC, writes the result back to both memory and ACC, and advances PC by 1, or by 2 on borrow. It sits directly upstream of the PC and ACC `register` instances: it produces their `in` values and `write` strobes, and it owns the memory request/acknowledge handshake.

## Interface
- `WIDTH`, 8: data word width; signed two's complement.
- `ADDR_W`, 8: memory address width; must satisfy ADDR_W ≤ WIDTH.
- `HALT_ADDR`, all-ones (ADDR_W bits): operand address that halts the machine.
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: reset, asynchronous and active-low.
- `run`  in  1: level-sensitive; starts execution, and allows it to continue.
- `mem_req`  out  1: memory request valid.
- `mem_we`  out  1: 1 = write, 0 = read; valid while `mem_req` is high.
- `mem_addr`  out  ADDR_W: request address.
- `mem_wdata`  out  WIDTH: write data.
- `mem_rdata`  in  WIDTH: read data; valid in the cycle `mem_ack` is high.
- `mem_ack`  in  1: completes the pending request; may rise in the same cycle as `mem_req`.
- `pc`  out  ADDR_W: PC register output.
- `acc`  out  WIDTH signed: ACC register output.
- `borrow`  out  1: borrow flag of the last executed instruction.
- `halted`  out  1: high in HALT.

## Operation
- States: IDLE, FETCH, LOAD, EXEC, STORE, HALT.
- IDLE: `mem_req` = 0. Go to FETCH when `run` = 1.
- FETCH: read mem[PC]. On ack, latch operand A = mem_rdata[ADDR_W-1:0].
  - If A == HALT_ADDR, go to HALT.
  - Otherwise go to LOAD.
- LOAD: read mem[A]. On ack, latch the data word D and go to EXEC.
- EXEC: single cycle, no memory request.
  - R = D − ACC, computed modulo 2^WIDTH.
  - `borrow` = R[WIDTH-1], the sign bit of the wrapped difference.
  - The ACC register is written with R.
  - Go to STORE.
- STORE: write mem[A] = R. On ack:
  - PC ← PC + 1, or PC + 2 if `borrow` = 1, modulo 2^ADDR_W (wraps through 0).
  - Go to FETCH if `run` = 1, else go to IDLE.
- Deasserting `run` mid-instruction has no effect until the STORE ack; the current instruction always completes.
- HALT: absorbing state. `halted` = 1, `mem_req` = 0. Only reset exits.
- Handshake rules:
  - `mem_req`, `mem_we`, `mem_addr` and `mem_wdata` stay stable from request assertion until the cycle `mem_ack` is sampled high.
  - `mem_ack` sampled while `mem_req` = 0 is ignored.
  - Exactly one transfer completes per ack.
- Reset (`rst` low), asynchronous and at any time, including mid-handshake:
  - State → IDLE.
  - `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `pc`, `acc`, `borrow`, `halted` all → 0.
  - Any in-flight request is abandoned.

## Timing
- Each memory state asserts `mem_req` combinationally from its state, in the first cycle of that state.
- With zero-wait memory (ack in the same cycle as req), one instruction takes 4 cycles: FETCH, LOAD, EXEC, STORE.
- Each wait cycle on any access adds exactly 1 cycle.
- ACC updates at the EXEC→STORE edge. `acc` shows R during STORE.
- PC updates at the STORE-ack edge. The next FETCH uses the new PC.
- `borrow` updates at the EXEC edge and holds until the next EXEC.
- From `run` rising in IDLE, FETCH is entered at the next edge: the request appears 1 cycle after `run` is sampled.
- HALT is entered at the FETCH-ack edge. No LOAD is issued for HALT_ADDR.

## Structure
- Shared package `rssb_pkg`:
  - state enum `rssb_state_t`;
  - default `WIDTH`/`ADDR_W` localparams;
  - `HALT_ADDR` default.
- PC and ACC are instances of the existing `register` module, with its reset polarity adapted at the instantiation.
- Natural sub-module: `rssb_alu`, combinational. Computes R and borrow and is instantiated once; the reverse-subtract is isolated there for unit checks.
- Next-PC adder and FSM stay in the top.

## Test plan
- Reset mid-LOAD (`mem_req` high) → all outputs 0 in the same cycle; state IDLE after release.
- Zero-wait memory; mem[0]=5, mem[5]=10, ACC=0, `run`=1 →
  - `acc`=10, `borrow`=0, mem[5]=10, `pc`=1;
  - `mem_req` observed for exactly 3 transfers over 4 cycles.
- Borrow case: ACC=3, mem[A]=1 →
  - R=−2 (0xFE), `borrow`=1;
  - PC advances by 2; PC=255 wraps to 1.
- Wrap case: mem[A]=−128, ACC=1 → R=+127 (0x7F), `borrow`=0, PC+1.
- Memory with 3 wait cycles on LOAD → address and control held stable for 4 cycles; instruction completes in 7 cycles.
- Operand 0xFF fetched → HALT at ack edge, `halted`=1, no further `mem_req`. `run` dropped mid-EXEC on a normal instruction → STORE completes, then IDLE.
